// File: rtl/vga_pf_pkg.sv
// Shared definitions for the VGA line prefetcher.
// Holds the default frame geometry, the fetch FSM encoding and the helper
// that turns a source row number into its SDRAM start address.
package vga_pf_pkg;

   localparam int SRC_W_DEF  = 320;
   localparam int SRC_H_DEF  = 240;
   localparam int ADDR_W_DEF = 20;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      REQ  = ST_REQ,
      WAIT = ST_WAIT
   } fetch_state_t;

   // Start address of a source row; only evaluated when a fetch is loaded,
   // the per-pixel address then just increments.
   function automatic logic [ADDR_W_DEF-1:0] row_base(
      input logic [ADDR_W_DEF-1:0] base,
      input int unsigned           row,
      input int unsigned           src_w
   );
      return base + ADDR_W_DEF'(row * src_w);
   endfunction

endpackage

// File: rtl/line_buffer_dp.sv
// Ping-pong line buffer storage: simple dual-port RAM, one write port and
// one registered read port on a single clock. The address is {bank, col};
// entries past the last column of each bank are never touched.
// Ports:
//   clk      clock
//   i_we     write enable
//   i_waddr  write address {bank, col}
//   i_wdata  write data
//   i_raddr  read address {bank, col}
//   o_rdata  read data, one clock after i_raddr
module line_buffer_dp #(
   parameter int DATA_W = 3,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
   logic [DATA_W-1:0] r_rdata;

   // Read-before-write: a read of the cell being written returns old data.
   always_ff @(posedge clk) begin
      if (i_we)
         r_mem[i_waddr] <= i_wdata;
      r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/vga_line_prefetcher.sv
// Prefetches 320-pixel source rows from SDRAM into a ping-pong line buffer
// and serves them with 2x horizontal / 2x vertical replication to the VGA
// pixel path. Source row r always lives in bank r&1.
// Ports:
//   clk, rst                 pixel clock, async active-high reset
//   frame_start, line_start  timing pulses from the VGA sync generator
//   x, y, video_on           current display position and visible flag
//   start_read, read_addr    one-cycle read request to the SDRAM controller
//   read_pixel, read_valid   read return
//   pixel_out                RGB, one clock after x/y/video_on
//   busy                     fetch in progress
//   underrun                 sticky: a fetch trigger had to be dropped
//
// state | meaning
// IDLE  | no fetch in progress
// REQ   | issue one read for (row, col)
// WAIT  | one read outstanding, waiting for read_valid
module vga_line_prefetcher
   import vga_pf_pkg::*;
#(
   parameter int                SRC_W     = SRC_W_DEF,
   parameter int                SRC_H     = SRC_H_DEF,
   parameter int                ADDR_W    = ADDR_W_DEF,
   parameter int                PIX_W     = 3,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              frame_start,
   input  logic              line_start,
   input  logic [9:0]        x,
   input  logic [9:0]        y,
   input  logic              video_on,
   output logic              start_read,
   output logic [ADDR_W-1:0] read_addr,
   input  logic [15:0]       read_pixel,
   input  logic              read_valid,
   output logic [PIX_W-1:0]  pixel_out,
   output logic              busy,
   output logic              underrun
);

   localparam int COL_W = $clog2(SRC_W);
   localparam int ROW_W = $clog2(SRC_H);

   fetch_state_t      r_state;
   logic              r_bank;
   logic [COL_W-1:0]  r_col;
   logic [ADDR_W-1:0] r_addr;
   logic              r_pend;
   logic [ROW_W-1:0]  r_pend_row;
   logic              r_restart;
   logic              r_underrun;
   logic              r_von_d;

   logic              w_line_trig;
   logic [ROW_W-1:0]  w_line_row;
   logic              w_last;
   logic              w_start;
   logic [ROW_W-1:0]  w_start_row;
   logic              w_take_line;
   logic              w_take_pend;
   logic [ADDR_W-1:0] w_row_base;
   logic              w_we;
   logic [PIX_W-1:0]  w_ram_q;

   // Display line y (even) finished with row y/2-1, so row y/2+1 can go
   // into that bank; the last source row is covered by the y=2*SRC_H-4 trigger.
   assign w_line_trig = line_start && !y[0] && (y >= 10'd2) &&
                        (y <= 10'(2*SRC_H-4));
   assign w_line_row  = ROW_W'((y >> 1) + 10'd1);
   assign w_last      = (r_col == COL_W'(SRC_W-1));

   always_comb begin
      w_start     = 1'b0;
      w_start_row = '0;
      w_take_line = 1'b0;
      w_take_pend = 1'b0;
      case (r_state)
         IDLE: begin
            if (frame_start) begin
               w_start = 1'b1;
            end else if (w_line_trig) begin
               w_start     = 1'b1;
               w_start_row = w_line_row;
               w_take_line = 1'b1;
            end
         end
         REQ: begin
            if (frame_start)
               w_start = 1'b1;
         end
         WAIT: begin
            if (read_valid) begin
               if (r_restart || frame_start) begin
                  w_start = 1'b1;
               end else if (w_last && r_pend) begin
                  w_start     = 1'b1;
                  w_start_row = r_pend_row;
                  w_take_pend = 1'b1;
               end else if (w_last && w_line_trig) begin
                  w_start     = 1'b1;
                  w_start_row = w_line_row;
                  w_take_line = 1'b1;
               end
            end
         end
         default: begin
            w_start = 1'b0;
         end
      endcase
   end

   assign w_row_base = ADDR_W'(row_base(ADDR_W_DEF'(BASE_ADDR),
                                        32'(w_start_row), 32'(SRC_W)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_bank  <= 1'b0;
         r_col   <= '0;
         r_addr  <= '0;
      end else if (w_start) begin
         r_state <= REQ;
         r_bank  <= w_start_row[0];
         r_col   <= '0;
         r_addr  <= w_row_base;
      end else begin
         case (r_state)
            REQ: r_state <= WAIT;
            WAIT: begin
               if (read_valid) begin
                  r_addr <= r_addr + 1'b1;
                  if (w_last) begin
                     r_state <= IDLE;
                  end else begin
                     r_col   <= r_col + 1'b1;
                     r_state <= REQ;
                  end
               end
            end
            default: r_state <= r_state;
         endcase
      end
   end

   // A frame_start during WAIT must let the outstanding read land first;
   // its data is thrown away and the fetch restarts at row 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_restart <= 1'b0;
      else if (r_state == WAIT && read_valid)
         r_restart <= 1'b0;
      else if (r_state == WAIT && frame_start)
         r_restart <= 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pend     <= 1'b0;
         r_pend_row <= '0;
         r_underrun <= 1'b0;
      end else if (frame_start) begin
         r_pend     <= 1'b1;
         r_pend_row <= ROW_W'(1);
      end else if (w_line_trig && !w_take_line) begin
         if (!r_pend || w_take_pend) begin
            r_pend     <= 1'b1;
            r_pend_row <= w_line_row;
         end else begin
            r_underrun <= 1'b1;
         end
      end else if (w_take_pend) begin
         r_pend <= 1'b0;
      end
   end

   assign w_we = (r_state == WAIT) && read_valid && !r_restart && !frame_start;

   line_buffer_dp #(
      .DATA_W (PIX_W),
      .ADDR_W (COL_W + 1)
   ) u_buf (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr ({r_bank, r_col}),
      .i_wdata (PIX_W'(read_pixel)),
      .i_raddr ({y[1], COL_W'(x >> 1)}),
      .o_rdata (w_ram_q)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_von_d <= 1'b0;
      else
         r_von_d <= video_on;
   end

   // frame_start in REQ abandons the request before it reaches the bus.
   assign start_read = (r_state == REQ) && !frame_start;
   assign read_addr  = r_addr;
   assign busy       = (r_state != IDLE);
   assign underrun   = r_underrun;
   assign pixel_out  = r_von_d ? w_ram_q : '0;

endmodule

// File: tb/tb_vga_line_prefetcher.sv
module tb_vga_line_prefetcher;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        frame_start = 1'b0;
   logic        line_start = 1'b0;
   logic [9:0]  x = '0;
   logic [9:0]  y = '0;
   logic        video_on = 1'b0;
   logic        start_read;
   logic [19:0] read_addr;
   logic [15:0] read_pixel = '0;
   logic        read_valid = 1'b0;
   logic [2:0]  pixel_out;
   logic        busy;
   logic        underrun;

   int total = 0;
   int bad   = 0;
   int lat   = 2;
   bit chk_addr  = 1'b1;
   bit chk_pix   = 1'b0;
   bit resp_busy = 1'b0;
   int exp_q[$];

   logic [2:0] mbuf [2][320];
   logic [9:0] cap_x = '0;
   logic [9:0] cap_y = '0;
   logic       cap_v = 1'b0;

   always #20 clk = ~clk;

   vga_line_prefetcher dut (
      .clk         (clk),
      .rst         (rst),
      .frame_start (frame_start),
      .line_start  (line_start),
      .x           (x),
      .y           (y),
      .video_on    (video_on),
      .start_read  (start_read),
      .read_addr   (read_addr),
      .read_pixel  (read_pixel),
      .read_valid  (read_valid),
      .pixel_out   (pixel_out),
      .busy        (busy),
      .underrun    (underrun)
   );

   // SDRAM contents: low 3 bits differ per row so bank mix-ups show up.
   function automatic logic [15:0] mem_word(input int a);
      int r;
      r = a / 320;
      return 16'((r << 8) | ((a + r) & 7));
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_row(input int r, input int lo, input int hi);
      logic [15:0] w;
      for (int c = lo; c <= hi; c++) begin
         w = mem_word(r * 320 + c);
         mbuf[r & 1][c] = w[2:0];
      end
   endtask

   task automatic push_addrs(input int lo, input int hi);
      for (int a = lo; a <= hi; a++)
         exp_q.push_back(a);
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n;
      n = 0;
      while (busy && n < budget) begin
         tick();
         n++;
      end
      chk(name, int'(busy), 0);
   endtask

   task automatic pulse_line(input int yy);
      y = 10'(yy);
      line_start = 1'b1;
      tick();
      line_start = 1'b0;
   endtask

   task automatic pulse_frame();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   // SDRAM read responder with programmable latency (cycles from start_read).
   initial begin
      int a;
      forever begin
         @(posedge clk);
         if (start_read && !rst) begin
            a = int'(read_addr);
            resp_busy = 1'b1;
            repeat (lat - 1) @(posedge clk);
            #1;
            read_valid = 1'b1;
            read_pixel = mem_word(a);
            @(posedge clk);
            #1;
            read_valid = 1'b0;
            resp_busy  = 1'b0;
         end
      end
   end

   always @(posedge clk) begin
      cap_x <= x;
      cap_y <= y;
      cap_v <= video_on;
   end

   // Per-cycle checker against the address queue and the buffer model.
   always @(negedge clk) begin
      if (!rst) begin
         if (start_read && chk_addr) begin
            if (exp_q.size() == 0)
               chk("read_unexpected", int'(read_addr), -1);
            else
               chk("read_addr", int'(read_addr), exp_q.pop_front());
         end
         if (start_read && resp_busy)
            chk("one_outstanding", 1, 0);
         if (chk_pix)
            chk("pixel_model", int'(pixel_out),
                cap_v ? int'(mbuf[cap_y[1]][cap_x >> 1]) : 0);
      end
   end

   initial begin
      int n;

      // Reset state
      repeat (3) tick();
      chk("rst_start_read", int'(start_read), 0);
      chk("rst_read_addr",  int'(read_addr),  0);
      chk("rst_pixel_out",  int'(pixel_out),  0);
      chk("rst_busy",       int'(busy),       0);
      chk("rst_underrun",   int'(underrun),   0);
      rst = 1'b0;
      tick();

      // Initial load, 3 cycles per pixel, busy low on cycle 1921 after frame_start
      push_addrs(0, 639);
      pulse_frame();
      n = 1;
      while (busy && n < 5000) begin
         tick();
         n++;
      end
      chk("load_busy_drop_cycle", n, 1921);
      chk("load_queue_empty", exp_q.size(), 0);
      model_row(0, 0, 319);
      model_row(1, 0, 319);

      // Pixel replication
      chk_pix = 1'b1;
      y = 10'd0;
      video_on = 1'b1;
      for (int i = 0; i < 8; i++) begin
         x = 10'(i);
         tick();
         chk("rep_y0", int'(pixel_out), i / 2);
      end
      y = 10'd1;
      for (int i = 0; i < 8; i++) begin
         x = 10'(i);
         tick();
         chk("rep_y1", int'(pixel_out), i / 2);
      end
      video_on = 1'b0;
      x = 10'd4;
      tick();
      chk("rep_video_off", int'(pixel_out), 0);
      y = 10'd2;
      video_on = 1'b1;
      for (int i = 0; i < 4; i++) begin
         x = 10'(i);
         tick();
         chk("rep_row1", int'(pixel_out), (i / 2 + 1) & 7);
      end
      video_on = 1'b0;

      // Steady state: y=2 fetches row 2
      push_addrs(640, 959);
      pulse_line(2);
      wait_idle("row2_done", 2000);
      chk("row2_queue_empty", exp_q.size(), 0);
      model_row(2, 0, 319);
      y = 10'd4;
      video_on = 1'b1;
      for (int i = 0; i < 16; i++) begin
         x = 10'(i);
         tick();
      end
      x = 10'd0;
      tick();
      chk("row2_px0", int'(pixel_out), 2);
      video_on = 1'b0;

      pulse_line(3);
      repeat (5) tick();
      chk("odd_line_no_fetch", int'(busy), 0);
      pulse_line(0);
      repeat (5) tick();
      chk("y0_line_no_fetch", int'(busy), 0);

      push_addrs(76480, 76799);
      pulse_line(476);
      wait_idle("row239_done", 2000);
      chk("row239_queue_empty", exp_q.size(), 0);
      model_row(239, 0, 319);

      pulse_line(478);
      repeat (20) tick();
      chk("y478_no_fetch", int'(busy), 0);
      chk("y478_queue_empty", exp_q.size(), 0);

      // Slow controller and underrun
      chk_addr = 1'b0;
      lat = 10;
      pulse_line(2);
      chk("ur_after_1", int'(underrun), 0);
      repeat (19) tick();
      pulse_line(4);
      chk("ur_after_2", int'(underrun), 0);
      repeat (19) tick();
      pulse_line(6);
      chk("ur_after_3", int'(underrun), 1);
      repeat (50) tick();
      chk("ur_sticky", int'(underrun), 1);
      chk("busy_before_rst", int'(busy), 1);

      // Reset mid-frame
      rst = 1'b1;
      #1;
      chk("mid_rst_start_read", int'(start_read), 0);
      chk("mid_rst_read_addr",  int'(read_addr),  0);
      chk("mid_rst_pixel_out",  int'(pixel_out),  0);
      chk("mid_rst_busy",       int'(busy),       0);
      chk("mid_rst_underrun",   int'(underrun),   0);
      repeat (3) tick();
      rst = 1'b0;
      n = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (start_read || read_addr != 0 || pixel_out != 0 || busy || underrun)
            n++;
      end
      chk("rst_stays_zero", n, 0);
      n = 0;
      while (resp_busy && n < 50) begin
         tick();
         n++;
      end
      chk("resp_drained", int'(resp_busy), 0);
      tick();

      // Restart during WAIT at row 5 col 100
      lat = 2;
      chk_addr = 1'b1;
      push_addrs(0, 639);
      pulse_frame();
      wait_idle("reload_done", 3000);
      chk("reload_queue_empty", exp_q.size(), 0);
      model_row(0, 0, 319);
      model_row(1, 0, 319);

      push_addrs(1600, 1700);
      pulse_line(8);
      n = 0;
      while (!(start_read && read_addr == 20'd1700) && n < 2000) begin
         tick();
         n++;
      end
      chk("reach_r5c100", int'(read_addr), 1700);
      tick();
      chk("r5c100_in_wait", int'(start_read), 0);
      push_addrs(0, 639);
      pulse_frame();
      model_row(5, 0, 99);
      y = 10'd2;
      video_on = 1'b1;
      x = 10'd198;
      tick();
      chk("restart_col99_row5", int'(pixel_out), 0);
      x = 10'd200;
      tick();
      chk("restart_col100_kept", int'(pixel_out), 5);
      x = 10'd202;
      tick();
      chk("restart_col101_kept", int'(pixel_out), 6);
      video_on = 1'b0;
      wait_idle("restart_done", 3000);
      chk("restart_queue_empty", exp_q.size(), 0);
      model_row(0, 0, 319);
      model_row(1, 0, 319);
      y = 10'd3;
      video_on = 1'b1;
      for (int i = 196; i < 204; i++) begin
         x = 10'(i);
         tick();
      end
      video_on = 1'b0;
      tick();
      chk_pix = 1'b0;
      chk("restart_no_underrun", int'(underrun), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
